// File: rtl/photon_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : photon_count_sequencer
//  Description : Run-level controller for the PMT photon-counting lock-in
//                datapath. Sequences settle/clear/integrate/latch/handoff for
//                a run of integration windows, with periodic dark windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module photon_count_sequencer #(
    parameter int CNT_W = 32,
    parameter int IDX_W = 16
) (
    input  logic             main_clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window_cycles,
    input  logic [IDX_W-1:0] settle_cycles,
    input  logic [IDX_W-1:0] num_windows,
    input  logic [7:0]       dark_every,
    output logic             mod_enable,
    output logic             count_clear,
    output logic             count_enable,
    output logic             count_latch,
    output logic             window_dark,
    output logic [IDX_W-1:0] window_index,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CLEAR     = 3'd2,
        ST_INTEGRATE = 3'd3,
        ST_LATCH     = 3'd4,
        ST_HANDOFF   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_min_window = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_one_cnt    = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_one_idx    = IDX_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_win_len;
    logic [CNT_W-1:0] r_int_cnt;
    logic [IDX_W-1:0] r_settle_len;
    logic [IDX_W-1:0] r_settle_cnt;
    logic [IDX_W-1:0] r_last_idx;
    logic [7:0]       r_dark_every;
    logic [7:0]       r_dark_cnt;

    logic [CNT_W-1:0] w_win_len_in;
    logic [IDX_W-1:0] w_settle_len_in;
    logic [IDX_W-1:0] w_last_idx_in;
    logic [7:0]       w_dark_cnt_first;
    logic [7:0]       w_dark_cnt_next;
    logic             w_dark_first;
    logic             w_dark_next;
    logic             w_start_go;

    // Configuration is clamped once at start so the run loop only needs
    // equality compares against latched values.
    assign w_win_len_in    = (window_cycles < c_min_window) ? c_min_window : window_cycles;
    assign w_settle_len_in = (settle_cycles == '0) ? c_one_idx : settle_cycles;
    assign w_last_idx_in   = (num_windows == '0) ? '0 : (num_windows - c_one_idx);
    assign w_start_go      = start && !abort;

    // Dark down-counter: reaching zero marks the last window of each period.
    assign w_dark_cnt_first = dark_every - 8'd1;
    assign w_dark_first     = (dark_every == 8'd1);
    assign w_dark_cnt_next  = (r_dark_cnt == 8'd0) ? (r_dark_every - 8'd1)
                                                   : (r_dark_cnt - 8'd1);
    assign w_dark_next      = (r_dark_every != 8'd0) && (w_dark_cnt_next == 8'd0);

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_win_len    <= '0;
            r_int_cnt    <= '0;
            r_settle_len <= '0;
            r_settle_cnt <= '0;
            r_last_idx   <= '0;
            r_dark_every <= '0;
            r_dark_cnt   <= '0;
            mod_enable   <= 1'b0;
            count_clear  <= 1'b0;
            count_enable <= 1'b0;
            count_latch  <= 1'b0;
            window_dark  <= 1'b0;
            window_index <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            count_clear  <= 1'b0;
            count_enable <= 1'b0;
            count_latch  <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;

            if (abort && (r_state != ST_IDLE)) begin
                r_state      <= ST_IDLE;
                mod_enable   <= 1'b0;
                window_dark  <= 1'b0;
                window_index <= '0;
                busy         <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_go) begin
                            r_win_len    <= w_win_len_in;
                            r_settle_len <= w_settle_len_in;
                            r_last_idx   <= w_last_idx_in;
                            r_dark_every <= dark_every;
                            r_dark_cnt   <= w_dark_cnt_first;
                            window_index <= '0;
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= c_one_idx;
                            window_dark  <= w_dark_first;
                            mod_enable   <= !w_dark_first;
                            busy         <= 1'b1;
                        end
                    end

                    ST_SETTLE: begin
                        if (r_settle_cnt == r_settle_len) begin
                            r_state     <= ST_CLEAR;
                            count_clear <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + c_one_idx;
                        end
                    end

                    ST_CLEAR: begin
                        r_state      <= ST_INTEGRATE;
                        r_int_cnt    <= c_one_cnt;
                        count_enable <= 1'b1;
                    end

                    ST_INTEGRATE: begin
                        if (r_int_cnt == r_win_len) begin
                            r_state     <= ST_LATCH;
                            count_latch <= 1'b1;
                        end else begin
                            r_int_cnt    <= r_int_cnt + c_one_cnt;
                            count_enable <= 1'b1;
                        end
                    end

                    ST_LATCH: begin
                        r_state      <= ST_HANDOFF;
                        result_valid <= 1'b1;
                    end

                    ST_HANDOFF: begin
                        if (!result_ready) begin
                            result_valid <= 1'b1;
                        end else if (window_index == r_last_idx) begin
                            r_state     <= ST_DONE;
                            done        <= 1'b1;
                            mod_enable  <= 1'b0;
                            window_dark <= 1'b0;
                        end else begin
                            // Next window starts immediately, no idle gap.
                            window_index <= window_index + c_one_idx;
                            r_dark_cnt   <= w_dark_cnt_next;
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= c_one_idx;
                            window_dark  <= w_dark_next;
                            mod_enable   <= !w_dark_next;
                        end
                    end

                    ST_DONE: begin
                        r_state      <= ST_IDLE;
                        window_index <= '0;
                        busy         <= 1'b0;
                    end

                    default: begin
                        r_state      <= ST_IDLE;
                        mod_enable   <= 1'b0;
                        window_dark  <= 1'b0;
                        window_index <= '0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_photon_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_photon_count_sequencer
//  Description : Directed, scoreboard-driven bench for photon_count_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_photon_count_sequencer;

    localparam int CNT_W = 32;
    localparam int IDX_W = 16;

    logic             main_clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             result_ready = 1'b0;
    logic [CNT_W-1:0] window_cycles = '0;
    logic [IDX_W-1:0] settle_cycles = '0;
    logic [IDX_W-1:0] num_windows = '0;
    logic [7:0]       dark_every = '0;
    logic             mod_enable, count_clear, count_enable, count_latch;
    logic             window_dark, result_valid, busy, done;
    logic [IDX_W-1:0] window_index;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];
    logic [16:0] win_q[$];

    photon_count_sequencer #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .main_clock   (main_clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .window_cycles(window_cycles),
        .settle_cycles(settle_cycles),
        .num_windows  (num_windows),
        .dark_every   (dark_every),
        .mod_enable   (mod_enable),
        .count_clear  (count_clear),
        .count_enable (count_enable),
        .count_latch  (count_latch),
        .window_dark  (window_dark),
        .window_index (window_index),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .done         (done)
    );

    always #10 main_clock = ~main_clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pack_out();
        return {busy, done, result_valid, window_dark, count_latch,
                count_enable, count_clear, mod_enable, window_index};
    endfunction

    // Expected outputs for cycle c of a single clean window (N=1, no dark).
    function automatic logic [23:0] single_exp(input int c, input int s, input int w);
        logic [7:0] f;
        f[7] = (c >= 1) && (c <= s + w + 4);
        f[6] = (c == s + w + 4);
        f[5] = (c == s + w + 3);
        f[4] = 1'b0;
        f[3] = (c == s + w + 2);
        f[2] = (c >= s + 2) && (c <= s + w + 1);
        f[1] = (c == s + 1);
        f[0] = (c >= 1) && (c <= s + w + 3);
        return {f, 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge main_clock);
        #1;
    endtask

    task automatic set_cfg(input int s, input int w, input int n, input int d);
        settle_cycles = IDX_W'(s);
        window_cycles = CNT_W'(w);
        num_windows   = IDX_W'(n);
        dark_every    = 8'(d);
    endtask

    // Caller raises start; cycle 1 is the cycle after the sampling edge.
    task automatic run_single(input int s, input int w, input string tag, input bit scramble);
        int last;
        last = s + w + 5;
        for (int c = 1; c <= last; c++) exp_q.push_back(single_exp(c, s, w));
        for (int c = 1; c <= last; c++) begin
            tick();
            start = 1'b0;
            if (scramble && c == 1) set_cfg(9, 50, 7, 1);
            chk($sformatf("%s_c%0d", tag, c), {8'h00, pack_out()}, {8'h00, exp_q.pop_front()});
        end
    endtask

    initial begin
        int latches;
        int dones;
        bit found;

        // Reset held with start toggling
        reset_n = 1'b0;
        set_cfg(3, 10, 1, 0);
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            tick();
            chk($sformatf("rst_hold_%0d", i), {8'h00, pack_out()}, 32'h0);
        end
        start = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Single window S=3 W=10 N=1
        result_ready = 1'b1;
        set_cfg(3, 10, 1, 0);
        start = 1'b1;
        run_single(3, 10, "single", 1'b0);

        // N=6, dark every 3rd window
        set_cfg(2, 3, 6, 3);
        for (int k = 0; k < 6; k++) win_q.push_back({((k % 3) == 2), 16'(k)});
        latches = 0;
        dones = 0;
        start = 1'b1;
        for (int i = 0; i < 200 && dones == 0; i++) begin
            tick();
            start = 1'b0;
            if (count_latch) begin
                latches++;
                if (win_q.size() > 0) begin
                    logic [16:0] e;
                    e = win_q.pop_front();
                    chk($sformatf("dark_idx_%0d", latches), {16'h0, window_index}, {16'h0, e[15:0]});
                    chk($sformatf("dark_flag_%0d", latches), {31'h0, window_dark}, {31'h0, e[16]});
                    chk($sformatf("dark_mod_%0d", latches), {31'h0, mod_enable}, {31'h0, !e[16]});
                end
            end
            if (done) dones++;
        end
        chk("dark_latches", latches, 6);
        chk("dark_dones", dones, 1);
        chk("dark_queue_left", win_q.size(), 0);
        tick();
        chk("dark_busy_end", {31'h0, busy}, 32'h0);

        // Backpressure in HANDOFF
        set_cfg(1, 2, 2, 0);
        result_ready = 1'b0;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            start = 1'b0;
            found = result_valid;
        end
        chk("bp_reach_handoff", {31'h0, found}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("bp_hold_%0d", i),
                {29'h0, result_valid, count_enable, window_index == 16'd0}, 32'h5);
        end
        result_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'h0, result_valid}, 32'h0);
        chk("bp_release_idx", {16'h0, window_index}, 32'h1);
        chk("bp_release_mod", {30'h0, busy, mod_enable}, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            found = done;
        end
        chk("bp_done", {31'h0, found}, 32'h1);
        tick();

        // Abort mid-INTEGRATE of window 1
        set_cfg(2, 8, 3, 0);
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            start = 1'b0;
            found = count_enable && (window_index == 16'd1);
        end
        chk("abort_reach_w1", {31'h0, found}, 32'h1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outputs", {8'h00, pack_out()}, 32'h0);
        latches = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (count_latch) latches++;
            if (done) dones++;
        end
        chk("abort_no_latch", latches, 0);
        chk("abort_no_done", dones, 0);

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_start", {31'h0, busy}, 32'h0);

        // Normal run after abort
        set_cfg(3, 10, 1, 0);
        start = 1'b1;
        run_single(3, 10, "post_abort", 1'b0);

        // Async reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #5;
        reset_n = 1'b0;
        #1;
        chk("async_rst", {8'h00, pack_out()}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("async_rst_idle", {31'h0, busy}, 32'h0);

        // Degenerate config with inputs scrambled mid-run
        set_cfg(0, 1, 0, 0);
        start = 1'b1;
        run_single(1, 2, "degen", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
